// File: rtl/ds_operand_fwd.sv
// Decode-stage operand slot: holds one decoded instruction, resolves rj/rk from
// the regfile or the youngest matching producer, and stalls only on a not-ready result.
module ds_operand_fwd #(
  parameter int NUM_FWD   = 3,
  parameter int PAYLOAD_W = 150,
  parameter int CNT_W     = 16
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   in_valid,
  output logic                   in_allowin,
  input  logic [31:0]            in_pc,
  input  logic [4:0]             in_rj,
  input  logic [4:0]             in_rk,
  input  logic                   in_rj_used,
  input  logic                   in_rk_used,
  input  logic [PAYLOAD_W-1:0]   in_payload,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_pc,
  output logic [PAYLOAD_W-1:0]   out_payload,
  output logic [31:0]            out_rj_value,
  output logic [31:0]            out_rk_value,
  input  logic                   flush,
  output logic [4:0]             rf_raddr1,
  output logic [4:0]             rf_raddr2,
  input  logic [31:0]            rf_rdata1,
  input  logic [31:0]            rf_rdata2,
  input  logic [NUM_FWD-1:0]     fwd_valid,
  input  logic [NUM_FWD-1:0]     fwd_we,
  input  logic [5*NUM_FWD-1:0]   fwd_dest,
  input  logic [32*NUM_FWD-1:0]  fwd_data,
  input  logic [NUM_FWD-1:0]     fwd_data_ok,
  input  logic                   stall_clr,
  output logic [CNT_W-1:0]       stall_cnt
);

  logic                 r_slot_valid;
  logic [31:0]          r_pc;
  logic [4:0]           r_rj;
  logic [4:0]           r_rk;
  logic                 r_rj_used;
  logic                 r_rk_used;
  logic [PAYLOAD_W-1:0] r_payload;
  logic [CNT_W-1:0]     r_stall_cnt;

  logic [32:0]          w_rj_res;
  logic [32:0]          w_rk_res;
  logic                 w_ready_go;
  logic                 w_allowin;
  logic                 w_cnt_max;

  // Scanning from oldest to youngest lets the youngest match overwrite older ones.
  // Result is {hazard, value}.
  function automatic logic [32:0] f_resolve(
    input logic [4:0]             src,
    input logic                   used,
    input logic [31:0]            rdata,
    input logic [NUM_FWD-1:0]     vld,
    input logic [NUM_FWD-1:0]     we,
    input logic [5*NUM_FWD-1:0]   dest,
    input logic [32*NUM_FWD-1:0]  data,
    input logic [NUM_FWD-1:0]     ok
  );
    logic [31:0] val;
    logic        haz;
    logic        match;
    val = rdata;
    haz = 1'b0;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      match = vld[i] & we[i] & (dest[5*i +: 5] == src) & (src != 5'd0) & used;
      val   = match ? data[32*i +: 32] : val;
      haz   = match ? ~ok[i] : haz;
    end
    val = (src == 5'd0) ? 32'h0 : val;
    return {haz, val};
  endfunction

  // Operand resolution and slot handshake on the held source registers.
  always_comb begin
    w_rj_res   = f_resolve(r_rj, r_rj_used, rf_rdata1, fwd_valid, fwd_we,
                           fwd_dest, fwd_data, fwd_data_ok);
    w_rk_res   = f_resolve(r_rk, r_rk_used, rf_rdata2, fwd_valid, fwd_we,
                           fwd_dest, fwd_data, fwd_data_ok);
    w_ready_go = ~(w_rj_res[32] | w_rk_res[32]);
    w_allowin  = ~r_slot_valid | (w_ready_go & out_ready);
    w_cnt_max  = (r_stall_cnt == {CNT_W{1'b1}});
  end

  assign in_allowin   = w_allowin;
  assign out_valid    = r_slot_valid & w_ready_go;
  assign out_pc       = r_pc;
  assign out_payload  = r_payload;
  assign out_rj_value = w_rj_res[31:0];
  assign out_rk_value = w_rk_res[31:0];
  assign rf_raddr1    = r_rj;
  assign rf_raddr2    = r_rk;
  assign stall_cnt    = r_stall_cnt;

  // Slot valid: flush wins over a same-cycle capture.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_slot_valid <= 1'b0;
    end else if (flush) begin
      r_slot_valid <= 1'b0;
    end else if (w_allowin) begin
      r_slot_valid <= in_valid;
    end else begin
      r_slot_valid <= r_slot_valid;
    end
  end

  // Held instruction fields.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pc      <= 32'h0;
      r_rj      <= 5'd0;
      r_rk      <= 5'd0;
      r_rj_used <= 1'b0;
      r_rk_used <= 1'b0;
      r_payload <= {PAYLOAD_W{1'b0}};
    end else if (in_valid && w_allowin) begin
      r_pc      <= in_pc;
      r_rj      <= in_rj;
      r_rk      <= in_rk;
      r_rj_used <= in_rj_used;
      r_rk_used <= in_rk_used;
      r_payload <= in_payload;
    end else begin
      r_pc      <= r_pc;
      r_rj      <= r_rj;
      r_rk      <= r_rk;
      r_rj_used <= r_rj_used;
      r_rk_used <= r_rk_used;
      r_payload <= r_payload;
    end
  end

  // Saturating hazard-stall counter.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_stall_cnt <= {CNT_W{1'b0}};
    end else if (stall_clr) begin
      r_stall_cnt <= {CNT_W{1'b0}};
    end else if (r_slot_valid && !w_ready_go && !w_cnt_max) begin
      r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      r_stall_cnt <= r_stall_cnt;
    end
  end

endmodule

// File: tb/tb_ds_operand_fwd.sv
// Bench for ds_operand_fwd: directed hazard scenarios, counter saturation and
// randomized traffic against a single-slot behavioural model.
module tb_ds_operand_fwd;
  localparam int N  = 3;
  localparam int PW = 150;
  localparam int CW = 16;

  logic            clk = 1'b0;
  logic            resetn;
  logic            in_valid, in_allowin;
  logic [31:0]     in_pc;
  logic [4:0]      in_rj, in_rk;
  logic            in_rj_used, in_rk_used;
  logic [PW-1:0]   in_payload;
  logic            out_valid, out_ready;
  logic [31:0]     out_pc;
  logic [PW-1:0]   out_payload;
  logic [31:0]     out_rj_value, out_rk_value;
  logic            flush;
  logic [4:0]      rf_raddr1, rf_raddr2;
  logic [31:0]     rf_rdata1, rf_rdata2;
  logic [N-1:0]    fwd_valid, fwd_we, fwd_data_ok;
  logic [5*N-1:0]  fwd_dest;
  logic [32*N-1:0] fwd_data;
  logic            stall_clr;
  logic [CW-1:0]   stall_cnt;

  logic [31:0] regs [32];
  assign rf_rdata1 = regs[rf_raddr1];
  assign rf_rdata2 = regs[rf_raddr2];

  ds_operand_fwd #(.NUM_FWD(N), .PAYLOAD_W(PW), .CNT_W(CW)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_allowin(in_allowin),
    .in_pc(in_pc), .in_rj(in_rj), .in_rk(in_rk), .in_rj_used(in_rj_used),
    .in_rk_used(in_rk_used), .in_payload(in_payload), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .out_payload(out_payload),
    .out_rj_value(out_rj_value), .out_rk_value(out_rk_value), .flush(flush),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1),
    .rf_rdata2(rf_rdata2), .fwd_valid(fwd_valid), .fwd_we(fwd_we),
    .fwd_dest(fwd_dest), .fwd_data(fwd_data), .fwd_data_ok(fwd_data_ok),
    .stall_clr(stall_clr), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model of the single decode slot.
  logic          m_valid;
  logic [31:0]   m_pc;
  logic [4:0]    m_rj, m_rk;
  logic          m_rju, m_rku;
  logic [PW-1:0] m_payload;
  int unsigned   m_cnt;
  logic          e_allow;
  logic          e_ready;

  task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Youngest producer that writes this register decides value and readiness.
  task automatic model_resolve(input logic [4:0] s, input logic used, output logic [31:0] val,
                               output logic haz);
    val = regs[s];
    haz = 1'b0;
    if (s == 5'd0) begin
      val = 32'h0;
    end else if (used) begin
      for (int i = 0; i < N; i++) begin
        if (fwd_valid[i] && fwd_we[i] && fwd_dest[5*i +: 5] == s) begin
          val = fwd_data[32*i +: 32];
          haz = !fwd_data_ok[i];
          break;
        end
      end
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_pc = 32'h0; m_rj = 5'd0; m_rk = 5'd0;
    m_rju = 1'b0; m_rku = 1'b0; m_payload = '0; m_cnt = 0;
  endtask

  task automatic step_check();
    logic [31:0] vj, vk;
    logic hj, hk;
    #1;
    model_resolve(m_rj, m_rju, vj, hj);
    model_resolve(m_rk, m_rku, vk, hk);
    e_ready = !(hj || hk);
    e_allow = !m_valid || (e_ready && out_ready);
    check_val("out_valid", 256'(out_valid), 256'(m_valid && e_ready));
    check_val("in_allowin", 256'(in_allowin), 256'(e_allow));
    check_val("stall_cnt", 256'(stall_cnt), 256'(m_cnt));
    if (m_valid) begin
      check_val("rf_raddr1", 256'(rf_raddr1), 256'(m_rj));
      check_val("rf_raddr2", 256'(rf_raddr2), 256'(m_rk));
      check_val("out_pc", 256'(out_pc), 256'(m_pc));
      check_val("out_payload", 256'(out_payload), 256'(m_payload));
      if (e_ready) begin
        check_val("out_rj_value", 256'(out_rj_value), 256'(vj));
        check_val("out_rk_value", 256'(out_rk_value), 256'(vk));
      end
    end
  endtask

  task automatic step_clock();
    @(posedge clk);
    if (stall_clr) m_cnt = 0;
    else if (m_valid && !e_ready && m_cnt < (2**CW - 1)) m_cnt++;
    if (in_valid && e_allow) begin
      m_pc = in_pc; m_rj = in_rj; m_rk = in_rk;
      m_rju = in_rj_used; m_rku = in_rk_used; m_payload = in_payload;
    end
    if (flush) m_valid = 1'b0;
    else if (e_allow) m_valid = in_valid;
    @(negedge clk);
  endtask

  task automatic step();
    step_check();
    step_clock();
  endtask

  task automatic clr_fwd();
    fwd_valid = '0; fwd_we = '0; fwd_dest = '0; fwd_data = '0; fwd_data_ok = '0;
  endtask

  task automatic set_fwd(input int i, input logic [4:0] d, input logic ok, input logic [31:0] v);
    fwd_valid[i] = 1'b1; fwd_we[i] = 1'b1; fwd_dest[5*i +: 5] = d;
    fwd_data_ok[i] = ok; fwd_data[32*i +: 32] = v;
  endtask

  task automatic load(input logic [4:0] rj, input logic ju, input logic [4:0] rk, input logic ku);
    in_valid = 1'b1; in_pc = $urandom; in_rj = rj; in_rk = rk;
    in_rj_used = ju; in_rk_used = ku;
    in_payload = {$urandom, $urandom, $urandom, $urandom, $urandom};
  endtask

  function automatic logic [4:0] pick_reg();
    case ($urandom_range(0, 4))
      0: return 5'd0;
      1: return 5'd3;
      2: return 5'd4;
      3: return 5'd5;
      default: return 5'($urandom);
    endcase
  endfunction

  initial begin
    for (int r = 0; r < 32; r++) regs[r] = $urandom;
    resetn = 1'b0; in_valid = 1'b0; in_pc = 32'h0; in_rj = 5'd0; in_rk = 5'd0;
    in_rj_used = 1'b0; in_rk_used = 1'b0; in_payload = '0; out_ready = 1'b1;
    flush = 1'b0; stall_clr = 1'b0;
    clr_fwd();
    model_reset();
    @(negedge clk);
    step_check();
    check_val("reset_out_pc", 256'(out_pc), 256'(0));
    @(negedge clk);
    resetn = 1'b1;

    // 1: ready producer in EX forwards immediately.
    load(5'd3, 1'b1, 5'd0, 1'b0);
    step();
    in_valid = 1'b0;
    set_fwd(0, 5'd3, 1'b1, 32'h55);
    step_check();
    check_val("t1_out_valid", 256'(out_valid), 256'(1));
    check_val("t1_rj_value", 256'(out_rj_value), 256'(32'h55));
    check_val("t1_stall_cnt", 256'(stall_cnt), 256'(0));
    step_clock();

    // 2: load-use, one stall then MEM result.
    clr_fwd();
    load(5'd0, 1'b0, 5'd5, 1'b1);
    step();
    in_valid = 1'b0;
    set_fwd(0, 5'd5, 1'b0, 32'h0);
    step_check();
    check_val("t2_stall", 256'(out_valid), 256'(0));
    step_clock();
    clr_fwd();
    set_fwd(1, 5'd5, 1'b1, 32'hDEAD);
    step_check();
    check_val("t2_out_valid", 256'(out_valid), 256'(1));
    check_val("t2_rk_value", 256'(out_rk_value), 256'(32'hDEAD));
    check_val("t2_stall_cnt", 256'(stall_cnt), 256'(1));
    step_clock();

    // 3: youngest (not ready) wins over older ready producer.
    clr_fwd();
    load(5'd4, 1'b1, 5'd0, 1'b0);
    step();
    in_valid = 1'b0;
    set_fwd(0, 5'd4, 1'b0, 32'h1);
    set_fwd(1, 5'd4, 1'b1, 32'h7);
    step_check();
    check_val("t3_youngest_stall", 256'(out_valid), 256'(0));
    step_clock();

    // 5: flush of a stalled slot beats a new capture.
    load(5'd1, 1'b1, 5'd2, 1'b1);
    flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    step_check();
    check_val("t5_flushed", 256'(out_valid), 256'(0));
    check_val("t5_allowin", 256'(in_allowin), 256'(1));
    step_clock();

    // 4: r0 never stalls and reads zero.
    clr_fwd();
    load(5'd0, 1'b1, 5'd0, 1'b1);
    step();
    in_valid = 1'b0;
    set_fwd(0, 5'd0, 1'b0, 32'hFFFF);
    step_check();
    check_val("t4_r0_valid", 256'(out_valid), 256'(1));
    check_val("t4_r0_value", 256'(out_rj_value), 256'(0));
    step_clock();

    // 6: reset mid-stall, then saturation.
    clr_fwd();
    stall_clr = 1'b1;
    load(5'd0, 1'b0, 5'd5, 1'b1);
    step();
    stall_clr = 1'b0; in_valid = 1'b0;
    set_fwd(0, 5'd5, 1'b0, 32'h0);
    for (int c = 0; c < 9; c++) step();
    step_check();
    check_val("t6_cnt9", 256'(stall_cnt), 256'(9));
    resetn = 1'b0;
    model_reset();
    #1;
    check_val("t6_rst_out_valid", 256'(out_valid), 256'(0));
    check_val("t6_rst_allowin", 256'(in_allowin), 256'(1));
    check_val("t6_rst_cnt", 256'(stall_cnt), 256'(0));
    @(negedge clk);
    resetn = 1'b1;
    load(5'd0, 1'b0, 5'd5, 1'b1);
    step();
    in_valid = 1'b0;
    for (int c = 0; c < (2**CW) + 4; c++) step();
    step_check();
    check_val("t6_saturated", 256'(stall_cnt), 256'({CW{1'b1}}));
    step_clock();

    // Randomized traffic.
    clr_fwd();
    stall_clr = 1'b1;
    step();
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 15) == 0) regs[$urandom_range(1, 31)] = $urandom;
      load(pick_reg(), 1'($urandom), pick_reg(), 1'($urandom));
      in_valid   = ($urandom_range(0, 3) != 0);
      out_ready  = ($urandom_range(0, 4) != 0);
      flush      = ($urandom_range(0, 19) == 0);
      stall_clr  = ($urandom_range(0, 31) == 0);
      for (int i = 0; i < N; i++) begin
        fwd_valid[i] = 1'($urandom);
        fwd_we[i] = ($urandom_range(0, 3) != 0);
        fwd_dest[5*i +: 5] = pick_reg();
        fwd_data[32*i +: 32] = $urandom;
        fwd_data_ok[i] = ($urandom_range(0, 9) < 7);
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
